// File: rtl/stage_if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package stage_if_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int INST_W_DEF = 32;

  // addi x0, x0, 0 -- the canonical bubble placed in IF/ID
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Sequential fetch stride in bytes
  localparam int PC_INC = 4;

  // Instruction field positions
  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/stage_if_if.sv
// Fetch-stage bundle: hazard control, instruction-memory handshake and IF/ID outputs.
interface stage_if_if #(
  parameter int PC_WIDTH       = 32,
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      pc_src;
  logic [PC_WIDTH-1:0]       branch_target;
  logic                      if_id_wr_en;
  logic                      if_id_flush;
  logic                      imem_req;
  logic [PC_WIDTH-1:0]       imem_addr;
  logic                      imem_rvalid;
  logic [INST_WIDTH-1:0]     imem_rdata;
  logic [PC_WIDTH-1:0]       IF_ID_pc;
  logic [INST_WIDTH-1:0]     IF_ID_inst;
  logic [6:0]                IF_ID_inst_opcode;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rd;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2;
  logic                      IF_ID_valid;
  logic                      if_stall;

  // The fetch stage itself
  modport master (
    input  pc_src, branch_target, if_id_wr_en, if_id_flush, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_inst_opcode,
           IF_ID_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_valid, if_stall
  );

  // Hazard unit, memory and decode stage surrounding it
  modport slave (
    output pc_src, branch_target, if_id_wr_en, if_id_flush, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_inst_opcode,
           IF_ID_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_valid, if_stall
  );
endinterface

// File: rtl/stage_if_if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; empty loads become bubbles.
module stage_if_if_id_reg import stage_if_pkg::*; #(
  parameter int PC_WIDTH       = PC_W_DEF,
  parameter int INST_WIDTH     = INST_W_DEF,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en_i,
  input  logic                      flush_i,
  input  logic                      dlv_i,
  input  logic [PC_WIDTH-1:0]       dlv_pc_i,
  input  logic [INST_WIDTH-1:0]     dlv_inst_i,
  output logic [PC_WIDTH-1:0]       pc_o,
  output logic [INST_WIDTH-1:0]     inst_o,
  output logic [OPC_W-1:0]          opcode_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_o,
  output logic                      valid_o
);

  logic [PC_WIDTH-1:0]   pc_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  valid_q;

  // Load, hold or bubble the IF/ID contents; PC is left alone on bubbles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      inst_q  <= INST_WIDTH'(NOP_INST);
      valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_q  <= INST_WIDTH'(NOP_INST);
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      if (dlv_i) begin
        pc_q    <= dlv_pc_i;
        inst_q  <= dlv_inst_i;
        valid_q <= 1'b1;
      end else begin
        inst_q  <= INST_WIDTH'(NOP_INST);
        valid_q <= 1'b0;
      end
    end
  end

  assign pc_o     = pc_q;
  assign inst_o   = inst_q;
  assign valid_o  = valid_q;
  assign opcode_o = inst_q[OPC_LSB +: OPC_W];
  assign rd_o     = inst_q[RD_LSB  +: REG_ADDR_WIDTH];
  assign rs1_o    = inst_q[RS1_LSB +: REG_ADDR_WIDTH];
  assign rs2_o    = inst_q[RS2_LSB +: REG_ADDR_WIDTH];

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, stall buffer, redirects.
module stage_if import stage_if_pkg::*; #(
  parameter int                  PC_WIDTH       = PC_W_DEF,
  parameter int                  INST_WIDTH     = INST_W_DEF,
  parameter int                  REG_ADDR_WIDTH = 5,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0
) (
  input logic       clk,
  input logic       reset_n,
  stage_if_if.master bus
);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  discard_q, discard_d;
  logic [PC_WIDTH-1:0]   buf_pc_q;
  logic [INST_WIDTH-1:0] buf_inst_q;
  logic                  buf_ld;
  logic                  req_d;
  logic [PC_WIDTH-1:0]   addr_d;
  logic                  dlv;
  logic [PC_WIDTH-1:0]   dlv_pc;
  logic [INST_WIDTH-1:0] dlv_inst;
  logic                  kept;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   nxt;

  assign pc_inc = pc_q + PC_WIDTH'(PC_INC);
  assign nxt    = bus.pc_src ? bus.branch_target : pc_inc;

  // Decide request, delivery, buffering and next PC/state for this cycle
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    req_d     = 1'b0;
    addr_d    = pc_q;
    buf_ld    = 1'b0;
    dlv       = 1'b0;
    dlv_pc    = pc_q;
    dlv_inst  = bus.imem_rdata;
    kept      = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        req_d     = 1'b1;
        addr_d    = bus.pc_src ? bus.branch_target : pc_q;
        pc_d      = addr_d;
        discard_d = 1'b0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.imem_rvalid) begin
          // Redirect while in flight: the eventual response is stale
          if (bus.pc_src) begin
            pc_d      = bus.branch_target;
            discard_d = 1'b1;
          end
        end else if (discard_q || bus.pc_src) begin
          // Drop the stale response and reissue on the correct path at once
          req_d     = 1'b1;
          addr_d    = bus.pc_src ? bus.branch_target : pc_q;
          pc_d      = addr_d;
          discard_d = 1'b0;
        end else begin
          kept = 1'b1;
          if (bus.if_id_wr_en) begin
            dlv    = 1'b1;
            pc_d   = nxt;
            req_d  = 1'b1;
            addr_d = nxt;
          end else begin
            buf_ld  = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        dlv_pc   = buf_pc_q;
        dlv_inst = buf_inst_q;
        if (bus.pc_src) begin
          pc_d    = bus.branch_target;
          state_d = ST_ISSUE;
        end else if (bus.if_id_wr_en) begin
          dlv     = 1'b1;
          pc_d    = pc_inc;
          req_d   = 1'b1;
          addr_d  = pc_inc;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  // Control state: FSM, PC and the stale-response flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ISSUE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  // One-entry buffer capturing a response that arrived during a stall
  always_ff @(posedge clk) begin
    if (buf_ld) begin
      buf_inst_q <= bus.imem_rdata;
      buf_pc_q   <= pc_q;
    end
  end

  // Requests are suppressed while reset is asserted
  assign bus.imem_req  = req_d & reset_n;
  assign bus.imem_addr = reset_n ? addr_d : pc_q;
  assign bus.if_stall  = (state_q == ST_ISSUE) || ((state_q == ST_WAIT) && !kept);

  stage_if_if_id_reg #(
    .PC_WIDTH       (PC_WIDTH),
    .INST_WIDTH     (INST_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en_i    (bus.if_id_wr_en),
    .flush_i    (bus.if_id_flush),
    .dlv_i      (dlv),
    .dlv_pc_i   (dlv_pc),
    .dlv_inst_i (dlv_inst),
    .pc_o       (bus.IF_ID_pc),
    .inst_o     (bus.IF_ID_inst),
    .opcode_o   (bus.IF_ID_inst_opcode),
    .rd_o       (bus.IF_ID_rd),
    .rs1_o      (bus.IF_ID_rs1),
    .rs2_o      (bus.IF_ID_rs2),
    .valid_o    (bus.IF_ID_valid)
  );

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for the fetch stage with a variable-latency instruction memory model.
module tb_stage_if;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  // Memory model controls
  int          mem_lat;
  logic        mem_fixed;
  logic [31:0] mem_fixed_data;
  logic        mem_pend_q;
  int          mem_cnt_q;
  logic [31:0] mem_addr_q;

  stage_if_if bus ();

  stage_if #(.RESET_PC(32'h100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-outstanding memory: responds mem_lat cycles after the request cycle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_pend_q <= 1'b0;
      mem_cnt_q  <= 0;
      mem_addr_q <= '0;
    end else if (bus.imem_req) begin
      mem_pend_q <= 1'b1;
      mem_cnt_q  <= mem_lat;
      mem_addr_q <= bus.imem_addr;
    end else if (mem_pend_q) begin
      if (mem_cnt_q == 1) mem_pend_q <= 1'b0;
      else mem_cnt_q <= mem_cnt_q - 1;
    end
  end

  assign bus.imem_rvalid = mem_pend_q && (mem_cnt_q == 1);
  assign bus.imem_rdata  = mem_fixed ? mem_fixed_data : (mem_addr_q >> 2);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.pc_src        = 1'b0;
    bus.branch_target = '0;
    bus.if_id_wr_en   = 1'b1;
    bus.if_id_flush   = 1'b0;
  endtask

  // Leaves the bench in the first cycle after release, inputs settled
  task automatic do_reset();
    reset_n = 1'b0;
    set_idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    mem_lat = 1; mem_fixed = 1'b0;
    reset_n = 1'b0;
    set_idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0h want 0", bus.imem_req); end
    n_chk++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_addr got %0h want 100", bus.imem_addr); end
    n_chk++; if (bus.IF_ID_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %0h want 0", bus.IF_ID_pc); end
    n_chk++; if (bus.IF_ID_inst !== 32'h13) begin n_fail++; $display("FAIL rst_inst got %0h want 13", bus.IF_ID_inst); end
    n_chk++; if (bus.IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0h want 0", bus.IF_ID_valid); end
    n_chk++; if (bus.IF_ID_inst_opcode !== 7'h13) begin n_fail++; $display("FAIL rst_opcode got %0h want 13", bus.IF_ID_inst_opcode); end
    reset_n = 1'b1;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %0h want 1", bus.imem_req); end
    n_chk++; if (bus.if_stall !== 1'b1) begin n_fail++; $display("FAIL first_stall got %0h want 1", bus.if_stall); end
  endtask

  task automatic test_back_to_back();
    mem_lat = 1; mem_fixed = 1'b0;
    do_reset();
    n_chk++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL b2b_a0 got %0h want 100", bus.imem_addr); end
    next_cycle(); #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin n_fail++; $display("FAIL b2b_a1 got req %0h addr %0h want 1/104", bus.imem_req, bus.imem_addr); end
    n_chk++; if (bus.IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_v1 got %0h want 0", bus.IF_ID_valid); end
    next_cycle(); #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108) begin n_fail++; $display("FAIL b2b_a2 got req %0h addr %0h want 1/108", bus.imem_req, bus.imem_addr); end
    n_chk++; if (bus.IF_ID_pc !== 32'h100 || bus.IF_ID_inst !== 32'h40 || bus.IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ifid0 got %0h/%0h/%0h want 100/40/1", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid); end
    next_cycle(); #1;
    n_chk++; if (bus.IF_ID_pc !== 32'h104 || bus.IF_ID_inst !== 32'h41 || bus.IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ifid1 got %0h/%0h/%0h want 104/41/1", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid); end
  endtask

  task automatic test_latency();
    int stalls;
    mem_lat = 3; mem_fixed = 1'b1; mem_fixed_data = 32'h00A0_0093;
    do_reset();
    stalls = 0;
    for (int i = 0; i < 10 && bus.IF_ID_valid !== 1'b1; i++) begin
      if (bus.if_stall === 1'b1) stalls++;
      next_cycle(); #1;
    end
    n_chk++; if (bus.IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL lat_timeout got valid %0h want 1", bus.IF_ID_valid); end
    n_chk++; if (stalls != 3) begin n_fail++; $display("FAIL lat_stalls got %0d want 3", stalls); end
    n_chk++; if (bus.IF_ID_pc !== 32'h100 || bus.IF_ID_inst !== 32'h00A00093) begin n_fail++; $display("FAIL lat_ifid got %0h/%0h want 100/a00093", bus.IF_ID_pc, bus.IF_ID_inst); end
    n_chk++; if (bus.IF_ID_inst_opcode !== 7'h13 || bus.IF_ID_rd !== 5'd1) begin n_fail++; $display("FAIL lat_opc_rd got %0h/%0d want 13/1", bus.IF_ID_inst_opcode, bus.IF_ID_rd); end
    n_chk++; if (bus.IF_ID_rs1 !== 5'd0 || bus.IF_ID_rs2 !== 5'd10) begin n_fail++; $display("FAIL lat_rs got %0d/%0d want 0/10", bus.IF_ID_rs1, bus.IF_ID_rs2); end
    mem_fixed = 1'b0;
  endtask

  task automatic test_hold();
    mem_lat = 1; mem_fixed = 1'b0;
    do_reset();
    next_cycle(); #1;
    next_cycle();
    bus.if_id_wr_en = 1'b0;
    #1;
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_capture_req got %0h want 0", bus.imem_req); end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      n_chk++; if (bus.imem_req !== 1'b0 || bus.if_stall !== 1'b0) begin n_fail++; $display("FAIL hold_idle got req %0h stall %0h want 0/0", bus.imem_req, bus.if_stall); end
      n_chk++; if (bus.IF_ID_pc !== 32'h100 || bus.IF_ID_inst !== 32'h40 || bus.IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL hold_ifid got %0h/%0h/%0h want 100/40/1", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid); end
    end
    next_cycle();
    bus.if_id_wr_en = 1'b1;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108) begin n_fail++; $display("FAIL hold_release_req got %0h/%0h want 1/108", bus.imem_req, bus.imem_addr); end
    next_cycle(); #1;
    n_chk++; if (bus.IF_ID_pc !== 32'h104 || bus.IF_ID_inst !== 32'h41 || bus.IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL hold_buffered got %0h/%0h/%0h want 104/41/1", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid); end
    n_chk++; if (bus.imem_addr !== 32'h10C) begin n_fail++; $display("FAIL hold_next_addr got %0h want 10c", bus.imem_addr); end
    next_cycle(); #1;
    n_chk++; if (bus.IF_ID_pc !== 32'h108 || bus.IF_ID_inst !== 32'h42) begin n_fail++; $display("FAIL hold_after got %0h/%0h want 108/42", bus.IF_ID_pc, bus.IF_ID_inst); end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3; mem_fixed = 1'b0;
    do_reset();
    next_cycle();
    bus.pc_src = 1'b1; bus.branch_target = 32'h200;
    #1;
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_wait_req got %0h want 0", bus.imem_req); end
    next_cycle();
    bus.pc_src = 1'b0;
    #1;
    next_cycle(); #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL redir_reissue got %0h/%0h want 1/200", bus.imem_req, bus.imem_addr); end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      n_chk++; if (bus.IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL redir_no_old got valid %0h pc %0h want 0", bus.IF_ID_valid, bus.IF_ID_pc); end
    end
    next_cycle(); #1;
    n_chk++; if (bus.IF_ID_pc !== 32'h200 || bus.IF_ID_inst !== 32'h80 || bus.IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL redir_target got %0h/%0h/%0h want 200/80/1", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid); end
  endtask

  task automatic test_hold_redirect();
    mem_lat = 1; mem_fixed = 1'b0;
    do_reset();
    next_cycle();
    bus.if_id_wr_en = 1'b0;
    #1;
    next_cycle();
    bus.pc_src = 1'b1; bus.branch_target = 32'h400; bus.if_id_wr_en = 1'b1;
    #1;
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hredir_req got %0h want 0", bus.imem_req); end
    next_cycle();
    bus.pc_src = 1'b0;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400 || bus.IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL hredir_issue got %0h/%0h/%0h want 1/400/0", bus.imem_req, bus.imem_addr, bus.IF_ID_valid); end
    next_cycle(); #1;
    next_cycle(); #1;
    n_chk++; if (bus.IF_ID_pc !== 32'h400 || bus.IF_ID_inst !== 32'h100 || bus.IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL hredir_target got %0h/%0h/%0h want 400/100/1", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid); end
  endtask

  task automatic test_flush_redirect();
    mem_lat = 1; mem_fixed = 1'b0;
    do_reset();
    next_cycle();
    bus.pc_src = 1'b1; bus.branch_target = 32'h300; bus.if_id_flush = 1'b1;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin n_fail++; $display("FAIL flush_req got %0h/%0h want 1/300", bus.imem_req, bus.imem_addr); end
    next_cycle();
    bus.pc_src = 1'b0; bus.if_id_flush = 1'b0;
    #1;
    n_chk++; if (bus.IF_ID_valid !== 1'b0 || bus.IF_ID_inst !== 32'h13) begin n_fail++; $display("FAIL flush_ifid got %0h/%0h want 0/13", bus.IF_ID_valid, bus.IF_ID_inst); end
    n_chk++; if (bus.imem_addr !== 32'h304) begin n_fail++; $display("FAIL flush_next got %0h want 304", bus.imem_addr); end
    next_cycle(); #1;
    n_chk++; if (bus.IF_ID_pc !== 32'h300 || bus.IF_ID_inst !== 32'hC0 || bus.IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL flush_target got %0h/%0h/%0h want 300/c0/1", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid); end
  endtask

  task automatic test_wrap();
    mem_lat = 1; mem_fixed = 1'b0;
    do_reset();
    bus.pc_src = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_issue got %0h/%0h want 1/fffffffc", bus.imem_req, bus.imem_addr); end
    next_cycle();
    bus.pc_src = 1'b0;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %0h/%0h want 1/0", bus.imem_req, bus.imem_addr); end
    next_cycle(); #1;
    n_chk++; if (bus.IF_ID_pc !== 32'hFFFF_FFFC || bus.IF_ID_inst !== 32'h3FFF_FFFF || bus.IF_ID_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_ifid got %0h/%0h/%0h want fffffffc/3fffffff/1", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    mem_lat = 1;
    mem_fixed = 1'b0;
    mem_fixed_data = '0;
    reset_n = 1'b0;
    set_idle();
    test_reset();
    test_back_to_back();
    test_latency();
    test_hold();
    test_redirect_wait();
    test_hold_redirect();
    test_flush_redirect();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety net against a runaway simulation
  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/stage_if.md
# stage_IF

Instruction-fetch stage of the 5-stage RISC-V pipeline and the producer side of the IF/ID pipeline register that stage_ID consumes. Owns the PC register. Issues one outstanding request at a time to instruction memory, which has variable latency. Loads the IF/ID register (PC, instruction and pre-sliced opcode/rs1/rs2/rd fields) under hazard-unit stall and flush control, and redirects on taken branches.

## Interface
Parameters:
- PC_WIDTH, default `PC_WIDTH (32): PC and address width.
- INST_WIDTH, default `INST_WIDTH (32): instruction width.
- REG_ADDR_WIDTH, default 5: register index width.
- RESET_PC, default 0: PC value loaded on reset.

Ports:
- clk  in  1  the single clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- pc_src  in  1  redirect request; 1 = taken branch or jump.
- branch_target  in  PC_WIDTH  redirect PC.
- if_id_wr_en  in  1  IF/ID write enable; 0 = stall from the hazard unit.
- if_id_flush  in  1  squash the IF/ID content.
- imem_req  out  1  one-cycle request strobe.
- imem_addr  out  PC_WIDTH  request address; valid while imem_req=1.
- imem_rvalid  in  1  response strobe; arrives 1 or more cycles after the request.
- imem_rdata  in  INST_WIDTH  response instruction.
- IF_ID_pc  out  PC_WIDTH  PC of the instruction held in IF/ID.
- IF_ID_inst  out  INST_WIDTH  instruction held in IF/ID.
- IF_ID_inst_opcode  out  7  IF_ID_inst[6:0].
- IF_ID_rd  out  REG_ADDR_WIDTH  IF_ID_inst[11:7].
- IF_ID_rs1  out  REG_ADDR_WIDTH  IF_ID_inst[19:15].
- IF_ID_rs2  out  REG_ADDR_WIDTH  IF_ID_inst[24:20].
- IF_ID_valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- if_stall  out  1  fetch is waiting on memory.

## Operation
- pc_q is the address of the instruction currently being fetched.
- nxt is combinational: nxt = branch_target when pc_src=1, otherwise pc_q+4. The addition wraps modulo 2^PC_WIDTH.
- State machine states: ISSUE, WAIT, HOLD. There is also a one-entry buffer register.

State ISSUE:
- imem_req=1.
- imem_addr = branch_target when pc_src=1, otherwise pc_q.
- pc_q takes imem_addr; next state is WAIT.

State WAIT, imem_rvalid=0:
- If pc_src=1: pc_q <= branch_target and the discard flag is set.

State WAIT, imem_rvalid=1, and the response is dropped (discard=1 or pc_src=1):
- Reissue in the same cycle: imem_req=1, imem_addr = pc_src ? branch_target : pc_q.
- pc_q takes imem_addr and discard is cleared.

State WAIT, imem_rvalid=1, response kept, if_id_wr_en=1:
- The response is delivered to IF/ID.
- pc_q <= pc_q+4.
- Back-to-back issue: imem_req=1, imem_addr = pc_q+4.
- The state stays WAIT.

State WAIT, imem_rvalid=1, response kept, if_id_wr_en=0:
- The data and pc_q go into the buffer; next state is HOLD; no request.

State HOLD:
- If pc_src=1: the buffer is dropped, pc_q <= branch_target, next state ISSUE.
- Else if if_id_wr_en=1: the buffer is delivered, pc_q <= pc_q+4, imem_req=1 with imem_addr = pc_q+4, next state WAIT.

IF/ID update, in priority order:
- if_id_flush=1: NOP 0x00000013 with IF_ID_valid=0. Any delivery in that cycle is squashed, but pc_q still advances.
- Else if if_id_wr_en=0: IF/ID holds its value.
- Else if a delivery happens: the delivered instruction and its PC, with IF_ID_valid=1.
- Else: a bubble, NOP with IF_ID_valid=0. IF_ID_pc keeps its previous value.

Other rules:
- if_stall = (state==ISSUE) or (state==WAIT and no kept response).
- imem_rvalid outside WAIT is ignored.

## Timing
- Reset values: state ISSUE, pc_q=RESET_PC, discard=0, imem_req=0, imem_addr=RESET_PC.
- IF/ID reset values: IF_ID_pc=0, IF_ID_inst=0x00000013, IF_ID_valid=0, fields sliced from that NOP.
- The first request goes out in the first cycle after reset deassertion.
- With 1-cycle memory: throughput is one instruction per cycle. Request to IF_ID_valid takes 2 edges.
- Redirect in ISSUE costs no dropped response. Redirect in WAIT or HOLD costs exactly one dropped response or buffer.
- Reset mid-request: an in-flight response that arrives after reset is released is ignored, because the state is ISSUE.

## Structure
- rv_fetch_pkg (or risc_v_defines.vh) holds: NOP_INST = 32'h00000013, the state encodings, the opcode/rs/rd bit positions, and the PC increment of 4.
- One natural sub-module: if_id_reg. It is the IF/ID register with wr_en/flush priority and the field slicing.
- The state machine, PC and buffer stay in stage_IF.

## Test plan
- Reset with RESET_PC=0x100 and 1-cycle memory returning addr/4 -> requests 0x100, 0x104, 0x108 on consecutive cycles; IF_ID_pc=0x100 with valid=1 two edges after release.
- Memory latency 3, rdata 0x00A00093 -> opcode 0x13, rd=1, rs1=0, rs2=10; if_stall=1 for 3 cycles per instruction.
- if_id_wr_en=0 for 4 cycles at the moment a response returns -> state HOLD, IF/ID held, no imem_req; after release the buffered instruction appears, then the next request goes to +4.
- pc_src=1 with target 0x200 in WAIT, response arriving 2 cycles later -> response dropped, next request at 0x200, no valid IF/ID from the old path.
- pc_src together with if_id_flush while a response arrives -> IF_ID_valid=0, NOP, same-cycle request to the target.
- PC=0xFFFFFFFC -> next request is 0x00000000.
